// File: rtl/packet_framer_ctrl.sv
// Packet framer: cuts a free-running sample stream into fixed-length packets,
// marks the final word with m_tlast, and pads a partial packet on disable.
module packet_framer_ctrl #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] PAD_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [2:0]        size_sel,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              busy,
  output logic              pkt_done,
  output logic [15:0]       pkt_count,
  output logic [11:0]       word_count
);

  typedef enum logic [1:0] {IDLE, RUN, PAD} state_t;

  state_t            state, state_nxt;
  logic [2:0]        cur_sel;
  logic [12:0]       len;
  logic              at_last;
  logic              load_ok;
  logic              load;
  logic [DATA_W-1:0] load_data;
  logic [11:0]       wc_nxt;
  logic              sel_latch;

  // len reaches 4096 for size_sel=7, so it needs 13 bits; word_count wraps
  // naturally from 4095.
  assign len       = 13'd32 << cur_sel;
  assign at_last   = ({1'b0, word_count} == (len - 13'd1));
  assign load_ok   = !m_tvalid || m_tready;
  assign busy      = (state != IDLE) || m_tvalid;
  // New length takes effect at a start or at the packet boundary only.
  assign sel_latch = ((state == IDLE) && enable) || (load && at_last);

  // Next-state, input handshake and output-register load selection.
  always_comb begin
    state_nxt = state;
    s_tready  = 1'b0;
    load      = 1'b0;
    load_data = PAD_VALUE;
    case (state)
      IDLE: begin
        if (enable) state_nxt = RUN;
      end
      RUN: begin
        s_tready = load_ok;
        if (s_tvalid && load_ok) begin
          load      = 1'b1;
          load_data = s_tdata;
        end
        // An accept in the same cycle as the drop still counts: a word that
        // closes the packet sends us straight to IDLE without padding.
        if (!enable) begin
          if ((load && at_last) || (!load && word_count == 12'd0))
            state_nxt = IDLE;
          else
            state_nxt = PAD;
        end
      end
      PAD: begin
        if (load_ok) begin
          load = 1'b1;
          if (at_last) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Word counter advance, wrapping after the last word of the packet.
  always_comb begin
    wc_nxt = word_count;
    if (load) wc_nxt = at_last ? 12'd0 : word_count + 12'd1;
  end

  // State, size latch and word counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cur_sel    <= 3'd0;
      word_count <= 12'd0;
    end else begin
      state      <= state_nxt;
      word_count <= wc_nxt;
      if (sel_latch) cur_sel <= size_sel;
    end
  end

  // One-stage output register; holds its word while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_tdata  <= '0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
    end else if (load) begin
      m_tdata  <= load_data;
      m_tvalid <= 1'b1;
      m_tlast  <= at_last;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
    end
  end

  // Completed-packet pulse and counter, one cycle after the last beat leaves.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_done  <= 1'b0;
      pkt_count <= 16'd0;
    end else begin
      pkt_done <= m_tvalid && m_tready && m_tlast;
      if (m_tvalid && m_tready && m_tlast) pkt_count <= pkt_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_packet_framer_ctrl.sv
// Directed bench for packet_framer_ctrl with a word scoreboard.
module tb_packet_framer_ctrl;

  localparam int          DATA_W = 32;
  localparam logic [31:0] PADV   = 32'hA5A5_5A5A;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              enable;
  logic [2:0]        size_sel;
  logic [DATA_W-1:0] s_tdata;
  logic              s_tvalid;
  logic              s_tready;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic              m_tlast;
  logic              busy;
  logic              pkt_done;
  logic [15:0]       pkt_count;
  logic [11:0]       word_count;

  packet_framer_ctrl #(.DATA_W(DATA_W), .PAD_VALUE(PADV)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .size_sel(size_sel),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .busy(busy), .pkt_done(pkt_done),
    .pkt_count(pkt_count), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int          nvec = 0;
  int          nerr = 0;
  logic [32:0] sb[$];       // {last, data}
  int          idx_m;       // words accepted into current packet (model)
  int          len_m;
  logic [2:0]  sel_m;
  bit          run_m;
  bit          exp_done;
  logic [15:0] pc_m;
  int          d_next;
  bit          rnd;
  bit          hold_pend;
  logic [31:0] hold_d;
  logic        hold_l;
  int          wc_max;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    sb.delete();
    idx_m = 0; run_m = 0; exp_done = 0; pc_m = 0; hold_pend = 0; sel_m = 0;
  endtask

  // One clock: observe at the falling edge, then drive just after the rising edge.
  task automatic tick();
    logic [32:0] e;
    @(negedge clk);
    if (reset_n) begin
      if (hold_pend) begin
        chk("hold_data", m_tdata, hold_d);
        chk("hold_last", {31'd0, m_tlast}, {31'd0, hold_l});
      end
      hold_pend = m_tvalid && !m_tready;
      hold_d = m_tdata;
      hold_l = m_tlast;
      if (exp_done) pc_m = pc_m + 16'd1;
      chk("pkt_done", {31'd0, pkt_done}, {31'd0, exp_done});
      chk("pkt_count", {16'd0, pkt_count}, {16'd0, pc_m});
      exp_done = 0;
      if (run_m) chk("word_count", {20'd0, word_count}, idx_m);
      if (m_tvalid && m_tready) begin
        if (sb.size() == 0) chk("unexpected_beat", {31'd0, m_tvalid}, 32'd0);
        else begin
          e = sb.pop_front();
          chk("data", m_tdata, e[31:0]);
          chk("last", {31'd0, m_tlast}, {31'd0, e[32]});
          exp_done = e[32];
        end
      end
      if (!run_m && enable) begin
        sel_m = size_sel;
        run_m = 1;
      end else if (run_m) begin
        len_m = 32 << sel_m;
        if (s_tvalid && s_tready) begin
          sb.push_back({(idx_m == len_m - 1), s_tdata});
          if (idx_m == len_m - 1) begin
            idx_m = 0;
            sel_m = size_sel;
          end else idx_m++;
          d_next++;
        end
        if (!enable) begin
          for (int k = idx_m; (idx_m != 0) && (k < len_m); k++)
            sb.push_back({(k == len_m - 1), PADV});
          idx_m = 0;
          run_m = 0;
        end
      end
      if (32'(word_count) > wc_max) wc_max = 32'(word_count);
    end
    @(posedge clk);
    #1;
    s_tdata = d_next;
    if (rnd) m_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic run_to(input int n);
    int b;
    b = 0;
    while (d_next < n && b < 20000) begin
      tick();
      b++;
    end
    if (d_next < n) chk("run_timeout", d_next, n);
  endtask

  task automatic stop_and_drain();
    int b;
    enable = 0;
    s_tvalid = 0;
    b = 0;
    while ((busy || sb.size() != 0) && b < 10000) begin
      tick();
      chk("s_tready_off", {31'd0, s_tready}, 32'd0);
      b++;
    end
    chk("drained_busy", {31'd0, busy}, 32'd0);
    chk("drained_sb", sb.size(), 0);
    tick();
    tick();
  endtask

  task automatic start(input logic [2:0] sel, input bit r);
    d_next = 0;
    s_tdata = 0;
    size_sel = sel;
    rnd = r;
    m_tready = 1;
    s_tvalid = 1;
    enable = 1;
  endtask

  initial begin
    reset_n = 0; enable = 0; size_sel = 0; s_tdata = 0; s_tvalid = 0;
    m_tready = 1; rnd = 0; d_next = 0; wc_max = 0; len_m = 32;
    model_clear();
    #12;
    chk("rst_s_tready", {31'd0, s_tready}, 32'd0);
    chk("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("rst_m_tlast", {31'd0, m_tlast}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_m_tdata", m_tdata, 32'd0);
    chk("rst_word_count", {20'd0, word_count}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1;
    tick();

    // Two 32-word packets at full throughput.
    start(3'd0, 0);
    run_to(64);
    stop_and_drain();
    chk("t1_pkt_count", {16'd0, pkt_count}, 32'd2);

    // Same stream with random downstream stalls.
    start(3'd0, 1);
    run_to(64);
    stop_and_drain();
    chk("t2_pkt_count", {16'd0, pkt_count}, 32'd4);
    rnd = 0; m_tready = 1;

    // Size change mid-packet applies to the next packet only.
    start(3'd0, 0);
    run_to(10);
    size_sel = 3'd1;
    run_to(96);
    stop_and_drain();
    chk("t3_pkt_count", {16'd0, pkt_count}, 32'd6);

    // Disable after 10 words: 22 pad words close the packet.
    start(3'd0, 0);
    run_to(10);
    stop_and_drain();
    chk("t4_pkt_count", {16'd0, pkt_count}, 32'd7);

    // Largest packet: 4096 words.
    wc_max = 0;
    start(3'd7, 0);
    run_to(4096);
    stop_and_drain();
    chk("t5_wc_max", wc_max, 4095);
    chk("t5_pkt_count", {16'd0, pkt_count}, 32'd8);

    // Reset in the middle of a 128-word packet.
    start(3'd2, 0);
    run_to(100);
    reset_n = 0;
    #1;
    chk("mid_rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("mid_rst_m_tdata", m_tdata, 32'd0);
    chk("mid_rst_m_tlast", {31'd0, m_tlast}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_s_tready", {31'd0, s_tready}, 32'd0);
    chk("mid_rst_pkt_count", {16'd0, pkt_count}, 32'd0);
    chk("mid_rst_word_count", {20'd0, word_count}, 32'd0);
    model_clear();
    @(posedge clk); @(posedge clk); #1;
    d_next = 0;
    s_tdata = 0;
    reset_n = 1;
    run_to(128);
    stop_and_drain();
    chk("t6_pkt_count", {16'd0, pkt_count}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/packet_framer_ctrl.md
Name: packet_framer_ctrl

Overview:
Sequences a free-running sample stream into fixed-length packets for the gyro tester DMA path. It counts accepted words, asserts m_tlast on the final word of each packet, and applies a new packet size only at packet boundaries. On disable it pads any partial packet to full length. Sits between the sample source and the AXI-stream DMA input, with a one-stage registered output.

Parameters:
DATA_W, 32, stream data width
PAD_VALUE, 0, data word inserted while padding a partial packet (DATA_W bits)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  level; 1 = frame the stream, 0 = finish current packet and stop
size_sel  in  3  packet length select; length = 32 << size_sel words (32..4096)
s_tdata  in  DATA_W  input sample
s_tvalid  in  1  input valid
s_tready  out  1  input ready
m_tdata  out  DATA_W  output word
m_tvalid  out  1  output valid
m_tready  in  1  downstream ready
m_tlast  out  1  last word of packet
busy  out  1  state != IDLE or m_tvalid
pkt_done  out  1  one-cycle pulse per completed packet
pkt_count  out  16  completed packets since reset, wraps 0xFFFF->0
word_count  out  12  words loaded into current packet, 0..length-1

Behaviour:
- Reset (async, reset_n=0): state IDLE; s_tready, m_tvalid, m_tlast, pkt_done, busy = 0; m_tdata = 0; word_count, pkt_count = 0; latched size = 0.
- Output register: load allowed when (!m_tvalid || m_tready). On load: m_tdata <= word, m_tvalid <= 1, m_tlast <= (word_count == len-1). If a beat transfers (m_tvalid & m_tready) with no load, m_tvalid <= 0 and m_tlast <= 0. Latency s_tdata -> m_tdata is 1 cycle; full throughput with m_tready=1.
- len = 32 << cur_sel; cur_sel is latched from size_sel on IDLE->RUN and whenever word_count wraps to 0. size_sel changes mid-packet have no effect on that packet.
- word_count increments on each load and wraps to 0 after the load of word len-1. 12-bit width; len 4096 wraps naturally from 4095.
- States:
  IDLE: s_tready=0. enable=1 -> latch size_sel, go RUN next cycle.
  RUN: s_tready = load-allowed. Accept = s_tvalid & s_tready loads s_tdata. If enable=0, evaluate word_count after this cycle's update: 0 -> IDLE, nonzero -> PAD.
  PAD: s_tready=0. Loads PAD_VALUE whenever load-allowed, until the word with m_tlast is loaded, then IDLE. enable is ignored in PAD.
- An enable drop and an accept in the same cycle: the accepted word counts, so a drop on the cycle that loads word len-1 goes straight to IDLE with no padding.
- pkt_done pulses, and pkt_count increments, in the cycle after m_tvalid & m_tready & m_tlast.
- Output register drains under m_tready in any state; IDLE does not clear a pending m_tvalid word.
- enable re-asserted in IDLE while m_tvalid=1 is legal; new packet words queue behind it normally.
- No word loss or duplication under any m_tready pattern; m_tdata/m_tlast stable while m_tvalid & !m_tready.

Test Plan:
- size_sel=0, enable=1, s_tvalid and m_tready always 1, data = incrementing from 0 -> m_tlast on word 31 (data 31) and word 63; pkt_done pulses the cycle after each; pkt_count=2 after 64 beats.
- Same stream with m_tready random at 50% -> output sequence 0,1,2,... with no gaps or repeats; m_tlast only on words 31 and 63; data held stable while stalled.
- Start with size_sel=0; change to 1 at word 10 -> first packet is 32 words, second packet is 64 words (m_tlast at global word 95).
- size_sel=0; drop enable after word 9 is accepted -> 22 PAD_VALUE words follow, m_tlast on the 22nd, s_tready=0 throughout padding, then IDLE, busy=0 once drained.
- size_sel=7 -> exactly 4096 words per packet; word_count reads 4095 before wrap; m_tlast on word 4095.
- Assert reset_n=0 at word 100 of a 128-word packet -> all outputs 0 immediately; after release with enable=1, the next packet starts at word_count 0 and is a full 128 words.
